// File: rtl/csr_ctrl.sv
// CSR/trap sequencer: latches one EXU request, computes the CSR file updates in a
// single EXEC cycle, then holds the old value and any PC redirect until the EXU accepts it.
module csr_ctrl #(
  parameter logic [31:0] MTVEC_ALIGN_MASK = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_src,
  input  logic        req_src_x0,
  input  logic [31:0] req_pc,
  input  logic [31:0] csr_rdata0,
  input  logic [31:0] csr_rdata1,
  input  logic [31:0] csr_rdata2,
  input  logic [31:0] csr_rdata3,
  input  logic [31:0] csr_rdata4,
  input  logic [31:0] csr_rdata5,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] wdata2,
  output logic [31:0] wdata3,
  output logic [31:0] wdata4,
  output logic [31:0] wdata5,
  output logic [5:0]  wen,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_redirect,
  output logic [31:0] resp_pc,
  output logic        resp_illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] src_q, pc_q;
  logic        src_x0_q;

  logic [31:0] rd [6];
  logic [31:0] wd [6];
  logic [5:0]  sel, wen_c;
  logic [31:0] old, newv, ms_ecall, ms_mret, rdata_c, pc_c;
  logic        redirect_c, illegal_c, exec_live;

  assign rd[0] = csr_rdata0;
  assign rd[1] = csr_rdata1;
  assign rd[2] = csr_rdata2;
  assign rd[3] = csr_rdata3;
  assign rd[4] = csr_rdata4;
  assign rd[5] = csr_rdata5;

  // rst only reaches outputs combinationally, never a flop D input
  assign req_ready  = (state == IDLE) && !rst;
  assign resp_valid = (state == RESP);
  assign exec_live  = (state == EXEC) && !rst;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      addr_q   <= '0;
      src_q    <= '0;
      src_x0_q <= 1'b0;
      pc_q     <= '0;
    end else if (state == IDLE && req_valid) begin
      op_q     <= req_op;
      addr_q   <= req_addr;
      src_q    <= req_src;
      src_x0_q <= req_src_x0;
      pc_q     <= req_pc;
    end
  end

  // one-hot lane select decoded from the latched address; all-zero marks an unknown CSR
  always_comb begin
    sel = '0;
    case (addr_q)
      12'h300: sel = 6'b000001;
      12'h341: sel = 6'b000010;
      12'h342: sel = 6'b000100;
      12'h340: sel = 6'b001000;
      12'h343: sel = 6'b010000;
      12'h305: sel = 6'b100000;
      default: sel = '0;
    endcase
    old = '0;
    for (int i = 0; i < 6; i++)
      if (sel[i]) old = old | rd[i];
  end

  always_comb begin
    ms_ecall        = rd[0];
    ms_ecall[7]     = rd[0][3];
    ms_ecall[3]     = 1'b0;
    ms_ecall[12:11] = 2'b11;
    ms_mret         = rd[0];
    ms_mret[3]      = rd[0][7];
    ms_mret[7]      = 1'b1;
    ms_mret[12:11]  = 2'b11;
    case (op_q)
      3'd1:    newv = old | src_q;
      3'd2:    newv = old & ~src_q;
      default: newv = src_q;
    endcase
  end

  always_comb begin
    wen_c      = '0;
    for (int i = 0; i < 6; i++) wd[i] = '0;
    rdata_c    = '0;
    pc_c       = '0;
    redirect_c = 1'b0;
    illegal_c  = 1'b0;
    case (op_q)
      3'd0, 3'd1, 3'd2: begin
        if (sel == 6'b0) begin
          illegal_c = 1'b1;
        end else begin
          rdata_c = old;
          if (op_q == 3'd0 || !src_x0_q) begin
            wen_c = sel;
            for (int i = 0; i < 6; i++)
              if (sel[i]) wd[i] = newv;
          end
        end
      end
      3'd3: begin
        wen_c      = 6'b000111;
        wd[0]      = ms_ecall;
        wd[1]      = pc_q;
        wd[2]      = 32'h0000_000B;
        redirect_c = 1'b1;
        pc_c       = rd[5] & MTVEC_ALIGN_MASK;
      end
      3'd4: begin
        wen_c      = 6'b000001;
        wd[0]      = ms_mret;
        redirect_c = 1'b1;
        pc_c       = rd[1];
      end
      default: illegal_c = 1'b1;
    endcase
  end

  // write port is live only during an un-reset EXEC cycle
  assign wen    = exec_live ? wen_c : 6'b0;
  assign wdata0 = exec_live ? wd[0] : 32'h0;
  assign wdata1 = exec_live ? wd[1] : 32'h0;
  assign wdata2 = exec_live ? wd[2] : 32'h0;
  assign wdata3 = exec_live ? wd[3] : 32'h0;
  assign wdata4 = exec_live ? wd[4] : 32'h0;
  assign wdata5 = exec_live ? wd[5] : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata    <= '0;
      resp_redirect <= 1'b0;
      resp_pc       <= '0;
      resp_illegal  <= 1'b0;
    end else if (state == EXEC) begin
      resp_rdata    <= rdata_c;
      resp_redirect <= redirect_c;
      resp_pc       <= pc_c;
      resp_illegal  <= illegal_c;
    end
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// Bench for csr_ctrl: the bench plays the CSR file and predicts every write and
// response from the architectural CSR rules.
module tb_csr_ctrl;

  logic        clk, rst;
  logic        req_valid, req_ready, req_src_x0;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_src, req_pc;
  logic [31:0] csr_rdata0, csr_rdata1, csr_rdata2, csr_rdata3, csr_rdata4, csr_rdata5;
  logic [31:0] wdata0, wdata1, wdata2, wdata3, wdata4, wdata5;
  logic [5:0]  wen;
  logic        resp_valid, resp_ready, resp_redirect, resp_illegal;
  logic [31:0] resp_rdata, resp_pc;

  logic [31:0] csr [6];
  logic [31:0] wd_dut [6];
  logic [11:0] addrMap [6];

  logic [5:0]  exp_wen;
  logic [31:0] exp_wd [6];
  logic [31:0] exp_rdata, exp_pc;
  logic        exp_redir, exp_ill;

  int total = 0;
  int bad   = 0;

  csr_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_src(req_src), .req_src_x0(req_src_x0), .req_pc(req_pc),
    .csr_rdata0(csr_rdata0), .csr_rdata1(csr_rdata1), .csr_rdata2(csr_rdata2),
    .csr_rdata3(csr_rdata3), .csr_rdata4(csr_rdata4), .csr_rdata5(csr_rdata5),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .wdata3(wdata3), .wdata4(wdata4), .wdata5(wdata5),
    .wen(wen),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_redirect(resp_redirect), .resp_pc(resp_pc), .resp_illegal(resp_illegal)
  );

  assign csr_rdata0 = csr[0];
  assign csr_rdata1 = csr[1];
  assign csr_rdata2 = csr[2];
  assign csr_rdata3 = csr[3];
  assign csr_rdata4 = csr[4];
  assign csr_rdata5 = csr[5];
  assign wd_dut[0] = wdata0;
  assign wd_dut[1] = wdata1;
  assign wd_dut[2] = wdata2;
  assign wd_dut[3] = wdata3;
  assign wd_dut[4] = wdata4;
  assign wd_dut[5] = wdata5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Architectural reference: what the CSR file should receive and what the EXU should see
  task automatic computeExpected(input logic [2:0] op, input logic [11:0] addr,
                                 input logic [31:0] src, input logic x0, input logic [31:0] pc);
    int idx;
    logic [31:0] ms;
    idx = -1;
    for (int i = 0; i < 6; i++) if (addrMap[i] == addr) idx = i;
    exp_wen = '0;
    for (int i = 0; i < 6; i++) exp_wd[i] = '0;
    exp_rdata = '0; exp_pc = '0; exp_redir = 1'b0; exp_ill = 1'b0;
    ms = csr[0];
    if (op <= 3'd2) begin
      if (idx < 0) exp_ill = 1'b1;
      else begin
        exp_rdata = csr[idx];
        if (op == 3'd0 || !x0) begin
          exp_wen[idx] = 1'b1;
          exp_wd[idx]  = (op == 3'd0) ? src : (op == 3'd1) ? (csr[idx] | src) : (csr[idx] & ~src);
        end
      end
    end else if (op == 3'd3) begin
      ms[7] = csr[0][3]; ms[3] = 1'b0; ms[12:11] = 2'b11;
      exp_wen = 6'b000111;
      exp_wd[0] = ms; exp_wd[1] = pc; exp_wd[2] = 32'd11;
      exp_redir = 1'b1; exp_pc = csr[5] & 32'hFFFF_FFFC;
    end else if (op == 3'd4) begin
      ms[3] = csr[0][7]; ms[7] = 1'b1; ms[12:11] = 2'b11;
      exp_wen = 6'b000001;
      exp_wd[0] = ms;
      exp_redir = 1'b1; exp_pc = csr[1];
    end else begin
      exp_ill = 1'b1;
    end
  endtask

  task automatic checkResp(input string tag);
    checkOutput({tag, ".valid"}, {31'b0, resp_valid}, 32'd1);
    checkOutput({tag, ".rdata"}, resp_rdata, exp_rdata);
    checkOutput({tag, ".redirect"}, {31'b0, resp_redirect}, {31'b0, exp_redir});
    checkOutput({tag, ".illegal"}, {31'b0, resp_illegal}, {31'b0, exp_ill});
    if (exp_redir) checkOutput({tag, ".pc"}, resp_pc, exp_pc);
    checkOutput({tag, ".wen_idle"}, {26'b0, wen}, 32'd0);
  endtask

  // One full transaction from an IDLE cycle (called at posedge+1)
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [11:0] addr,
                               input logic [31:0] src, input logic x0, input logic [31:0] pc,
                               input int hold);
    computeExpected(op, addr, src, x0, pc);
    req_op = op; req_addr = addr; req_src = src; req_src_x0 = x0; req_pc = pc;
    req_valid = 1'b1; resp_ready = 1'b0;
    checkOutput({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 3'($urandom); req_addr = 12'($urandom); req_src = $urandom; req_pc = $urandom;
    checkOutput({tag, ".exec_wen"}, {26'b0, wen}, {26'b0, exp_wen});
    for (int i = 0; i < 6; i++) checkOutput($sformatf("%s.wdata%0d", tag, i), wd_dut[i], exp_wd[i]);
    checkOutput({tag, ".exec_valid"}, {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) if (exp_wen[i]) csr[i] = exp_wd[i];
    for (int h = 0; h < hold; h++) begin
      checkResp(tag);
      req_valid = 1'b1;
      @(posedge clk); #1;
    end
    checkResp(tag);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checkOutput({tag, ".done_valid"}, {31'b0, resp_valid}, 32'd0);
    checkOutput({tag, ".ready_after"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    addrMap[0] = 12'h300; addrMap[1] = 12'h341; addrMap[2] = 12'h342;
    addrMap[3] = 12'h340; addrMap[4] = 12'h343; addrMap[5] = 12'h305;
    for (int i = 0; i < 6; i++) csr[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = '0; req_addr = '0; req_src = '0; req_src_x0 = 1'b0; req_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rst.wen", {26'b0, wen}, 32'd0);
    for (int i = 0; i < 6; i++) checkOutput($sformatf("rst.wdata%0d", i), wd_dut[i], 32'd0);
    checkOutput("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst.resp_flags", {30'b0, resp_redirect, resp_illegal}, 32'd0);
    checkOutput("rst.resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst.resp_pc", resp_pc, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed sequence");
    applyStimulus("csrrw_mtvec", 3'd0, 12'h305, 32'h8000_0100, 1'b0, 32'h0, 0);
    checkOutput("csrrw_mtvec.rdata_zero", resp_rdata, 32'd0);
    csr[0] = 32'h8;
    applyStimulus("csrrs", 3'd1, 12'h300, 32'h80, 1'b0, 32'h0, 0);
    csr[0] = 32'h8;
    applyStimulus("csrrs_x0", 3'd1, 12'h300, 32'h80, 1'b1, 32'h0, 1);
    csr[0] = 32'h8; csr[5] = 32'h8000_0103;
    applyStimulus("ecall", 3'd3, 12'h000, 32'h0, 1'b0, 32'h8000_0040, 0);
    csr[0] = 32'h1880; csr[1] = 32'h8000_0044;
    applyStimulus("mret", 3'd4, 12'h000, 32'h0, 1'b0, 32'h0, 0);
    applyStimulus("ill_addr", 3'd0, 12'h7C0, 32'h1234, 1'b0, 32'h0, 4);
    applyStimulus("ill_op", 3'd6, 12'h300, 32'h1234, 1'b0, 32'h0, 4);

    $display("[TB] reset during EXEC");
    req_op = 3'd0; req_addr = 12'h340; req_src = 32'hDEAD_BEEF; req_src_x0 = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("rstexec.wen_before", {26'b0, wen}, 32'b001000);
    #1 rst = 1'b1;
    #1;
    checkOutput("rstexec.wen_now", {26'b0, wen}, 32'd0);
    checkOutput("rstexec.wdata3_now", wdata3, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstexec.no_resp", {31'b0, resp_valid}, 32'd0);
    checkOutput("rstexec.idle", {31'b0, req_ready}, 32'd1);
    applyStimulus("after_rst", 3'd2, 12'h342, 32'h0000_00F0, 1'b0, 32'h0, 1);

    $display("[TB] randomized sequence");
    for (int n = 0; n < 60; n++) begin
      int r;
      logic [2:0] op;
      logic [11:0] addr;
      if (n % 8 == 0) for (int i = 0; i < 6; i++) csr[i] = $urandom;
      r = $urandom_range(0, 11);
      op = (r < 10) ? 3'(r % 5) : 3'($urandom_range(5, 7));
      addr = ($urandom_range(0, 9) < 8) ? addrMap[$urandom_range(0, 5)] : 12'($urandom);
      applyStimulus($sformatf("rnd%0d", n), op, addr, $urandom, 1'($urandom_range(0, 3) == 0),
                    $urandom, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_ctrl.md
# csr_ctrl

Multicycle CSR/trap sequencer directly upstream of the 6-entry machine CSR file. It accepts one CSR or trap request at a time from the EXU and reads the current CSR values from the file's read ports. It computes the next values and drives the file's per-register `wdata0..5` / `wen[5:0]` write ports for exactly one cycle. It then returns the old CSR value and any PC redirect to the EXU over a valid/ready handshake.

## Interface
Parameters:
- `MTVEC_ALIGN_MASK`, default `32'hFFFF_FFFC`: mask applied to mtvec to form the trap target.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE with `rst` low.
- `req_op` in 3: 0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 MRET; 5–7 illegal.
- `req_addr` in 12: CSR address. Used by ops 0–2 only.
- `req_src` in 32: rs1 value or zero-extended uimm.
- `req_src_x0` in 1: source is x0/uimm 0. Suppresses the write for CSRRS/CSRRC.
- `req_pc` in 32: PC of the instruction.
- `csr_rdata0..5` in 32 each: CSR file read ports.
- `wdata0..5` out 32 each: to CSR file write data.
- `wen` out 6: to CSR file write enables.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: EXU accepts response.
- `resp_rdata` out 32: old CSR value; 0 for ECALL, MRET and illegal requests.
- `resp_redirect` out 1: PC must be redirected.
- `resp_pc` out 32: redirect target.
- `resp_illegal` out 1: unknown op or address.

## Operation
- Index map: 0 mstatus `0x300`, 1 mepc `0x341`, 2 mcause `0x342`, 3 mscratch `0x340`, 4 mtval `0x343`, 5 mtvec `0x305`. Any other address is illegal.
- FSM states: IDLE, EXEC, RESP.
  - IDLE→EXEC on `req_valid & req_ready`. All `req_*` fields are latched at this edge.
  - EXEC→RESP unconditionally after one cycle.
  - RESP→IDLE on `resp_valid & resp_ready`.
- EXEC computes from the latched request and the live `csr_rdata*`. It drives `wen`/`wdata` this cycle only, and registers the response fields.
- CSRRW: `new = src`; write the indexed register; `resp_rdata = old`.
- CSRRS: `new = old | src`. CSRRC: `new = old & ~src`. If `req_src_x0`, `wen = 0` but `resp_rdata = old`.
- ECALL:
  - mepc ← pc; mcause ← `32'h0000_000B`.
  - mstatus: bit7 (MPIE) ← bit3 (MIE); bit3 ← 0; bits[12:11] (MPP) ← 2'b11; other bits unchanged.
  - `wen = 6'b000111`; redirect to `mtvec & MTVEC_ALIGN_MASK`.
- MRET:
  - mstatus: bit3 ← bit7; bit7 ← 1; bits[12:11] ← 2'b11.
  - `wen = 6'b000001`; redirect to `csr_rdata1` (mepc).
- Illegal op or address: `wen = 0`, `resp_illegal = 1`, `resp_rdata = 0`, no redirect.
- `wdata*` for disabled lanes is driven 0. Only EXEC may assert `wen`, and at most one request is in flight.

## Timing
- Reset: state IDLE and `req_ready = 0` while `rst` is high.
  - `wen = 0`, all `wdata* = 0`.
  - `resp_valid`, `resp_redirect` and `resp_illegal` are 0; `resp_rdata` and `resp_pc` are 0.
  - CSR file contents are untouched.
- Accept edge T. EXEC is cycle T+1, with `wen` high for exactly that cycle; the file updates at the end of T+1. `resp_valid` is first high in cycle T+2.
- `resp_*` hold stable while `resp_valid & ~resp_ready`.
- Throughput: a response handshake at edge R leaves `req_ready` high at R+1. Minimum 3 cycles per request.
- Asserting `rst` mid-EXEC deasserts `wen` immediately (async), so no partial write occurs. Mid-RESP, the response is dropped.
- `req_valid` changes while `req_ready` is low are ignored.

## Test plan
- Reset then CSRRW addr `0x305`, src `0x8000_0100`, mtvec old `0x0`. Required: `wen = 6'b100000` and `wdata5 = 0x8000_0100` in T+1 only; `resp_rdata = 0` in T+2.
- CSRRS mstatus old `0x0000_0008`, src `0x80`. Required: `wdata0 = 0x88`. Repeat with `req_src_x0 = 1`: `wen = 0` and `resp_rdata = 0x8`.
- ECALL pc `0x8000_0040`, mstatus `0x8`, mtvec `0x8000_0103`. Required:
  - `wen = 000111`; `wdata1 = 0x8000_0040`; `wdata2 = 0xB`; `wdata0 = 0x1880`.
  - `resp_redirect = 1`, `resp_pc = 0x8000_0100`.
- MRET mstatus `0x1880`, mepc `0x8000_0044`. Required: `wdata0 = 0x1888`, `resp_pc = 0x8000_0044`.
- Illegal addr `0x7C0`, then op 6. Required: `wen` stays 0, `resp_illegal = 1`; hold `resp_ready` low 4 cycles and check all `resp_*` stable.
- `rst` pulse during EXEC of a CSRRW. Required: `wen` drops in the same cycle, FSM returns to IDLE, no response is issued, and a following request completes normally.
